// File: rtl/opt_sequencer.sv
// opt_sequencer
//   Per-replica controller for the distance/delta datapath. Takes one move
//   proposal (2-opt / or-opt), issues the distance command steps that build
//   the energy delta, waits for the delta, makes the Metropolis decision and
//   holds the result until the replica update logic consumes it.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   opt_valid/ready     proposal handshake (ready only in IDLE)
//   opt[79:0]           {command[1:0], K[6:0], L[6:0], r_metropolis[31:0], r_exchange[31:0]}
//   beta_shift[3:0]     Metropolis threshold shift, sampled with opt
//   dist_cmd[4:0]       registered {select[2:0], op[1:0]} to the datapath
//   delta_valid, delta  one-cycle delta return, signed 3.17 (21 bits)
//   res_valid/ready     result handshake
//   res_accept          1 = move accepted
//   res_delta, res_opt  latched delta and proposal
//   err_thr             one-cycle pulse when a THR command is refused
//   err_timeout         one-cycle pulse when WAIT gives up
//
// state | meaning
// IDLE  | ready for a proposal
// ISSUE | driving one distance step per cycle
// WAIT  | waiting for delta_valid, bounded by TIMEOUT cycles
// JUDGE | Metropolis accept/reject on the latched delta
// OUT   | result presented until res_ready

module opt_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        opt_valid,
    output logic        opt_ready,
    input  logic [79:0] opt,
    input  logic [3:0]  beta_shift,
    output logic [4:0]  dist_cmd,
    input  logic        delta_valid,
    input  logic [20:0] delta,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_accept,
    output logic [20:0] res_delta,
    output logic [79:0] res_opt,
    output logic        err_thr,
    output logic        err_timeout
);

    localparam logic [1:0] CMD_TWO = 2'd0;
    localparam logic [1:0] CMD_OR0 = 2'd1;
    localparam logic [1:0] CMD_OR1 = 2'd2;
    localparam logic [1:0] CMD_THR = 2'd3;

    localparam logic [2:0] SEL_KP = 3'd0;
    localparam logic [2:0] SEL_KN = 3'd1;
    localparam logic [2:0] SEL_KM = 3'd2;
    localparam logic [2:0] SEL_LP = 3'd3;
    localparam logic [2:0] SEL_LN = 3'd4;
    localparam logic [2:0] SEL_LM = 3'd5;

    localparam logic [1:0] OP_DNOP = 2'd0;
    localparam logic [1:0] OP_ZERO = 2'd1;
    localparam logic [1:0] OP_PLS  = 2'd2;
    localparam logic [1:0] OP_MNS  = 2'd3;

    localparam logic [4:0] CMD_IDLE = {SEL_KN, OP_DNOP};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_JUDGE,
        S_OUT
    } state_t;

    state_t             r_state, w_state_n;
    logic [CNT_W-1:0]   r_cnt, w_cnt_n;
    logic [4:0]         r_dist, w_dist_n;
    logic               r_res_valid, w_res_valid_n;
    logic               r_accept, w_accept_n;
    logic [20:0]        r_delta, w_delta_n;
    logic [79:0]        r_opt, w_opt_n;
    logic [3:0]         r_shift, w_shift_n;
    logic               r_err_thr, w_err_thr_n;
    logic               r_err_to, w_err_to_n;

    logic               w_last_step;
    logic [19:0]        w_thresh;
    logic               w_accept;

    // Step table: {select, op} for each step of each move type.
    function automatic logic [4:0] step_cmd(input logic [1:0] cmd, input logic [CNT_W-1:0] step);
        logic [4:0] c;
        c = CMD_IDLE;
        case (cmd)
            CMD_TWO: begin
                case (step)
                    CNT_W'(0): c = {SEL_KP, OP_ZERO};
                    CNT_W'(1): c = {SEL_LP, OP_PLS};
                    CNT_W'(2): c = {SEL_KN, OP_MNS};
                    CNT_W'(3): c = {SEL_LN, OP_MNS};
                    default:   c = CMD_IDLE;
                endcase
            end
            CMD_OR0: begin
                case (step)
                    CNT_W'(0): c = {SEL_KP, OP_ZERO};
                    CNT_W'(1): c = {SEL_LP, OP_PLS};
                    CNT_W'(2): c = {SEL_LM, OP_PLS};
                    CNT_W'(3): c = {SEL_KN, OP_MNS};
                    CNT_W'(4): c = {SEL_LN, OP_MNS};
                    CNT_W'(5): c = {SEL_KM, OP_MNS};
                    default:   c = CMD_IDLE;
                endcase
            end
            CMD_OR1: begin
                case (step)
                    CNT_W'(0): c = {SEL_LP, OP_ZERO};
                    CNT_W'(1): c = {SEL_KP, OP_PLS};
                    CNT_W'(2): c = {SEL_KM, OP_PLS};
                    CNT_W'(3): c = {SEL_LN, OP_MNS};
                    CNT_W'(4): c = {SEL_KN, OP_MNS};
                    CNT_W'(5): c = {SEL_LM, OP_MNS};
                    default:   c = CMD_IDLE;
                endcase
            end
            default: c = CMD_IDLE;
        endcase
        return c;
    endfunction

    assign w_last_step = (r_opt[79:78] == CMD_TWO) ? (r_cnt == CNT_W'(3))
                                                   : (r_cnt == CNT_W'(5));

    // Threshold uses the low 20 bits of r_metropolis; a negative or zero
    // delta is always accepted, otherwise magnitude compare is unsigned.
    assign w_thresh = r_opt[51:32] >> r_shift;
    assign w_accept = r_delta[20] || (r_delta == 21'd0) || (r_delta[19:0] < w_thresh);

    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_dist_n      = CMD_IDLE;
        w_res_valid_n = r_res_valid;
        w_accept_n    = r_accept;
        w_delta_n     = r_delta;
        w_opt_n       = r_opt;
        w_shift_n     = r_shift;
        w_err_thr_n   = 1'b0;
        w_err_to_n    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (opt_valid) begin
                    if (opt[79:78] == CMD_THR) begin
                        w_err_thr_n = 1'b1;
                    end else begin
                        w_opt_n   = opt;
                        w_shift_n = beta_shift;
                        w_cnt_n   = '0;
                        w_state_n = S_ISSUE;
                        // dist_cmd is registered, so step 0 is loaded on the
                        // handshake edge and appears in the first ISSUE cycle.
                        w_dist_n  = step_cmd(opt[79:78], '0);
                    end
                end
            end
            S_ISSUE: begin
                if (w_last_step) begin
                    w_cnt_n   = '0;
                    w_state_n = S_WAIT;
                end else begin
                    w_cnt_n  = r_cnt + CNT_W'(1);
                    w_dist_n = step_cmd(r_opt[79:78], r_cnt + CNT_W'(1));
                end
            end
            S_WAIT: begin
                if (delta_valid) begin
                    w_delta_n = delta;
                    w_state_n = S_JUDGE;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_err_to_n = 1'b1;
                    w_cnt_n    = '0;
                    w_state_n  = S_IDLE;
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            S_JUDGE: begin
                w_accept_n    = w_accept;
                w_res_valid_n = 1'b1;
                w_state_n     = S_OUT;
            end
            S_OUT: begin
                if (res_ready) begin
                    w_res_valid_n = 1'b0;
                    w_state_n     = S_IDLE;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_dist      <= CMD_IDLE;
            r_res_valid <= 1'b0;
            r_accept    <= 1'b0;
            r_delta     <= '0;
            r_opt       <= '0;
            r_shift     <= '0;
            r_err_thr   <= 1'b0;
            r_err_to    <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_dist      <= w_dist_n;
            r_res_valid <= w_res_valid_n;
            r_accept    <= w_accept_n;
            r_delta     <= w_delta_n;
            r_opt       <= w_opt_n;
            r_shift     <= w_shift_n;
            r_err_thr   <= w_err_thr_n;
            r_err_to    <= w_err_to_n;
        end
    end

    assign opt_ready   = (r_state == S_IDLE);
    assign dist_cmd    = r_dist;
    assign res_valid   = r_res_valid;
    assign res_accept  = r_accept;
    assign res_delta   = r_delta;
    assign res_opt     = r_opt;
    assign err_thr     = r_err_thr;
    assign err_timeout = r_err_to;

endmodule

// File: tb/tb_opt_sequencer.sv
module tb_opt_sequencer;

    localparam logic [1:0] C_TWO = 2'd0;
    localparam logic [1:0] C_OR0 = 2'd1;
    localparam logic [1:0] C_OR1 = 2'd2;
    localparam logic [1:0] C_THR = 2'd3;

    localparam logic [2:0] KP = 3'd0;
    localparam logic [2:0] KN = 3'd1;
    localparam logic [2:0] KM = 3'd2;
    localparam logic [2:0] LP = 3'd3;
    localparam logic [2:0] LN = 3'd4;
    localparam logic [2:0] LM = 3'd5;

    localparam logic [1:0] DNOP = 2'd0;
    localparam logic [1:0] ZERO = 2'd1;
    localparam logic [1:0] PLS  = 2'd2;
    localparam logic [1:0] MNS  = 2'd3;

    localparam logic [4:0] IDLE_CMD = {KN, DNOP};

    logic        clk = 1'b0;
    logic        reset;
    logic        opt_valid;
    logic        opt_ready;
    logic [79:0] opt;
    logic [3:0]  beta_shift;
    logic [4:0]  dist_cmd;
    logic        delta_valid;
    logic [20:0] delta;
    logic        res_valid;
    logic        res_ready;
    logic        res_accept;
    logic [20:0] res_delta;
    logic [79:0] res_opt;
    logic        err_thr;
    logic        err_timeout;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    opt_sequencer #(.TIMEOUT(15), .CNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .opt_valid   (opt_valid),
        .opt_ready   (opt_ready),
        .opt         (opt),
        .beta_shift  (beta_shift),
        .dist_cmd    (dist_cmd),
        .delta_valid (delta_valid),
        .delta       (delta),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_accept  (res_accept),
        .res_delta   (res_delta),
        .res_opt     (res_opt),
        .err_thr     (err_thr),
        .err_timeout (err_timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int n_steps(input logic [1:0] c);
        return (c == C_TWO) ? 4 : 6;
    endfunction

    function automatic logic [4:0] exp_cmd(input logic [1:0] c, input int i);
        logic [4:0] r;
        r = IDLE_CMD;
        if (c == C_TWO) begin
            case (i)
                0: r = {KP, ZERO};
                1: r = {LP, PLS};
                2: r = {KN, MNS};
                3: r = {LN, MNS};
                default: r = IDLE_CMD;
            endcase
        end else if (c == C_OR0) begin
            case (i)
                0: r = {KP, ZERO};
                1: r = {LP, PLS};
                2: r = {LM, PLS};
                3: r = {KN, MNS};
                4: r = {LN, MNS};
                5: r = {KM, MNS};
                default: r = IDLE_CMD;
            endcase
        end else begin
            case (i)
                0: r = {LP, ZERO};
                1: r = {KP, PLS};
                2: r = {KM, PLS};
                3: r = {LN, MNS};
                4: r = {KN, MNS};
                5: r = {LM, MNS};
                default: r = IDLE_CMD;
            endcase
        end
        return r;
    endfunction

    // Metropolis rule on plain integers.
    function automatic logic exp_accept(input logic [20:0] d, input logic [31:0] rm, input int sh);
        int dv;
        int thr;
        dv  = int'($signed(d));
        thr = int'(rm & 32'h000F_FFFF) >>> sh;
        if (dv <= 0) return 1'b1;
        return (dv < thr) ? 1'b1 : 1'b0;
    endfunction

    // Run one move up to OUT; optionally hold the result and release it.
    task automatic run_move(input logic [1:0] c, input logic [6:0] k, input logic [6:0] l,
                            input logic [31:0] rm, input logic [31:0] rx, input logic [3:0] sh,
                            input logic [20:0] d, input int w, input int hold,
                            input bit rel, input bit noise);
        logic [79:0] o;
        logic        acc;
        o   = {c, k, l, rm, rx};
        acc = exp_accept(d, rm, int'(sh));
        check("opt_ready_before", opt_ready, 1);
        opt_valid  = 1'b1;
        opt        = o;
        beta_shift = sh;
        step();
        opt_valid  = 1'b0;
        opt        = {16'($urandom), $urandom, $urandom};
        beta_shift = 4'($urandom);
        check("opt_ready_busy", opt_ready, 0);
        for (int i = 0; i < n_steps(c); i++) begin
            check($sformatf("dist_cmd_step%0d", i), dist_cmd, exp_cmd(c, i));
            if (noise) begin
                delta_valid = 1'($urandom_range(0, 1));
                delta       = 21'($urandom);
            end
            step();
        end
        delta_valid = 1'b0;
        check("dist_cmd_wait", dist_cmd, IDLE_CMD);
        repeat (w - 1) step();
        delta_valid = 1'b1;
        delta       = d;
        step();
        delta_valid = 1'b0;
        delta       = 21'($urandom);
        check("res_valid_judge", res_valid, 0);
        step();
        check("res_valid", res_valid, 1);
        check("res_accept", res_accept, acc);
        check("res_delta", res_delta, d);
        check("res_opt", res_opt, o);
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_valid", res_valid, 1);
            check("hold_delta", res_delta, d);
            check("hold_opt", res_opt, o);
            check("hold_ready", opt_ready, 0);
        end
        if (rel) begin
            res_ready = 1'b1;
            step();
            res_ready = 1'b0;
            check("res_valid_cleared", res_valid, 0);
            check("opt_ready_after", opt_ready, 1);
        end
    endtask

    initial begin
        logic [79:0] last_opt;
        logic [79:0] bp_opt;
        bit          seen_res;
        reset       = 1'b1;
        opt_valid   = 1'b0;
        opt         = '0;
        beta_shift  = '0;
        delta_valid = 1'b0;
        delta       = '0;
        res_ready   = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Reset state
        check("rst_opt_ready", opt_ready, 1);
        check("rst_dist_cmd", dist_cmd, IDLE_CMD);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_accept", res_accept, 0);
        check("rst_res_delta", res_delta, 0);
        check("rst_res_opt", res_opt, 0);
        check("rst_err_thr", err_thr, 0);
        check("rst_err_timeout", err_timeout, 0);

        // TWO K=3 L=10, negative delta two cycles into WAIT
        run_move(C_TWO, 7'd3, 7'd10, 32'h1234_5678, 32'h9abc_def0, 4'd2,
                 21'h1FFF00, 3, 0, 1'b1, 1'b0);

        // OR1 threshold boundary around beta_shift
        run_move(C_OR1, 7'd5, 7'd20, 32'h0000_8000, 32'h0, 4'd4,
                 21'h000400, 1, 0, 1'b1, 1'b0);
        check("or1_shift4_accept", res_accept, 1);
        run_move(C_OR1, 7'd5, 7'd20, 32'h0000_8000, 32'h0, 4'd6,
                 21'h000400, 1, 0, 1'b1, 1'b0);
        check("or1_shift6_reject", res_accept, 0);
        last_opt = {C_OR1, 7'd5, 7'd20, 32'h0000_8000, 32'h0};

        // THR command refused
        opt_valid = 1'b1;
        opt       = {C_THR, 7'd1, 7'd2, 32'hffff_ffff, 32'h5555_5555};
        step();
        opt_valid = 1'b0;
        check("thr_err_pulse", err_thr, 1);
        check("thr_opt_ready", opt_ready, 1);
        check("thr_dist_cmd", dist_cmd, IDLE_CMD);
        check("thr_res_valid", res_valid, 0);
        check("thr_res_opt", res_opt, last_opt);
        step();
        check("thr_err_clear", err_thr, 0);
        check("thr_dist_cmd2", dist_cmd, IDLE_CMD);

        // Timeout after OR0 issue
        opt_valid  = 1'b1;
        opt        = {C_OR0, 7'd9, 7'd40, 32'h0000_1000, 32'h1};
        beta_shift = 4'd0;
        step();
        opt_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("to_dist_step%0d", i), dist_cmd, exp_cmd(C_OR0, i));
            step();
        end
        for (int i = 0; i < 14; i++) begin
            check($sformatf("to_wait%0d_ready", i), opt_ready, 0);
            check($sformatf("to_wait%0d_err", i), err_timeout, 0);
            step();
        end
        check("to_last_wait_ready", opt_ready, 0);
        step();
        check("to_err_pulse", err_timeout, 1);
        check("to_idle", opt_ready, 1);
        check("to_res_valid", res_valid, 0);
        delta_valid = 1'b1;
        delta       = 21'h000001;
        step();
        delta_valid = 1'b0;
        check("to_err_clear", err_timeout, 0);
        check("late_delta_ready", opt_ready, 1);
        check("late_delta_dist", dist_cmd, IDLE_CMD);
        repeat (3) step();
        check("late_delta_no_res", res_valid, 0);

        // Backpressure: result held 5 cycles with a new proposal waiting
        run_move(C_OR0, 7'd12, 7'd30, 32'h000F_0000, 32'h7, 4'd3,
                 21'h000123, 2, 0, 1'b0, 1'b0);
        bp_opt     = {C_TWO, 7'd44, 7'd2, 32'h0003_0000, 32'h2};
        opt_valid  = 1'b1;
        opt        = bp_opt;
        beta_shift = 4'd1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", res_valid, 1);
            check("bp_opt_ready", opt_ready, 0);
            check("bp_dist_cmd", dist_cmd, IDLE_CMD);
            check("bp_res_opt", res_opt, {C_OR0, 7'd12, 7'd30, 32'h000F_0000, 32'h7});
            check("bp_res_delta", res_delta, 21'h000123);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("bp_release_ready", opt_ready, 1);
        check("bp_release_valid", res_valid, 0);
        run_move(C_TWO, 7'd44, 7'd2, 32'h0003_0000, 32'h2, 4'd1,
                 21'h010000, 4, 1, 1'b1, 1'b0);

        // Reset during ISSUE step 2
        opt_valid  = 1'b1;
        opt        = {C_TWO, 7'd1, 7'd7, 32'h0, 32'h0};
        beta_shift = 4'd0;
        step();
        opt_valid = 1'b0;
        step();
        step();
        check("mid_dist_step2", dist_cmd, exp_cmd(C_TWO, 2));
        reset = 1'b1;
        #1;
        check("mid_rst_ready_async", opt_ready, 1);
        check("mid_rst_dist_async", dist_cmd, IDLE_CMD);
        step();
        reset = 1'b0;
        check("mid_rst_ready", opt_ready, 1);
        check("mid_rst_dist", dist_cmd, IDLE_CMD);
        check("mid_rst_valid", res_valid, 0);
        check("mid_rst_opt", res_opt, 0);
        seen_res    = 1'b0;
        delta_valid = 1'b1;
        delta       = 21'h1FFFFF;
        step();
        delta_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (res_valid || dist_cmd != IDLE_CMD) seen_res = 1'b1;
            step();
        end
        check("mid_rst_no_result", {79'd0, seen_res}, 0);

        // Randomized moves against the reference model
        for (int n = 0; n < 25; n++) begin
            logic [1:0]  c;
            logic [20:0] d;
            c = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1)
                d = 21'($urandom_range(0, 32'h000F_FFFF));
            else
                d = -21'($urandom_range(0, 32'h000F_FFFF));
            run_move(c, 7'($urandom), 7'($urandom), $urandom, $urandom,
                     4'($urandom), d, $urandom_range(1, 15),
                     $urandom_range(0, 3), 1'b1, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
